// File: rtl/perf_cnt_rsp_if.sv
// Host-side read/response handshake bundle for the performance-counter responder.
// The host owns rd_req/rsp_ready; the responder owns the remaining signals.
interface perf_cnt_rsp_if #(
  parameter int DW = 34
);
  logic          rd_req;
  logic          rd_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [2:0]    rsp_idx;
  logic          rsp_last;

  modport master (
    output rd_req, rsp_ready,
    input  rd_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
  );

  modport slave (
    input  rd_req, rsp_ready,
    output rd_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
  );
endinterface

// File: rtl/perf_cnt_rsp.sv
// Cycle and per-lane retire counters for the 4-issue core, read out by the host
// as a six-word snapshot stream: cycles, total, lane1..lane4.
module perf_cnt_rsp #(
  parameter int CNT_W = 32,
  parameter int DW    = CNT_W + 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    ex,
  input  logic          clr,
  perf_cnt_rsp_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] lane_q [4];
  logic [CNT_W-1:0] lane_d [4];
  logic [3:0]       ex_prev_q, ex_prev_d;
  logic [CNT_W-1:0] snap_cyc_q, snap_cyc_d;
  logic [CNT_W-1:0] snap_lane_q [4];
  logic [CNT_W-1:0] snap_lane_d [4];
  logic [DW-1:0]    snap_tot_q, snap_tot_d;
  logic [3:0]       rise;
  logic [DW-1:0]    lane_sum;
  logic             rsp_valid;
  logic [DW-1:0]    rsp_data;

  // Live counters run regardless of the read FSM; clr wins over any increment.
  always_comb begin
    rise      = ex & ~ex_prev_q;
    ex_prev_d = ex;
    cyc_d     = clr ? '0 : cyc_q + CNT_W'(1);
    for (int i = 0; i < 4; i++) begin
      lane_d[i] = clr ? '0 : lane_q[i] + CNT_W'(rise[i]);
    end
    lane_sum = DW'(lane_q[0]) + DW'(lane_q[1]) + DW'(lane_q[2]) + DW'(lane_q[3]);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_cyc_d  = snap_cyc_q;
    snap_tot_d  = snap_tot_q;
    snap_lane_d = snap_lane_q;
    case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          snap_cyc_d  = cyc_q;
          snap_lane_d = lane_q;
          snap_tot_d  = lane_sum;
          idx_d       = 3'd0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bus.rsp_ready) begin
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cyc_q      <= '0;
      ex_prev_q  <= '0;
      snap_cyc_q <= '0;
      snap_tot_q <= '0;
      for (int i = 0; i < 4; i++) begin
        lane_q[i]      <= '0;
        snap_lane_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cyc_q       <= cyc_d;
      ex_prev_q   <= ex_prev_d;
      snap_cyc_q  <= snap_cyc_d;
      snap_tot_q  <= snap_tot_d;
      lane_q      <= lane_d;
      snap_lane_q <= snap_lane_d;
    end
  end

  // Outputs read only the frozen snapshot, so backpressure keeps them stable.
  always_comb begin
    rsp_valid = (state_q == SEND);
    rsp_data  = '0;
    if (rsp_valid) begin
      case (idx_q)
        3'd0:    rsp_data = DW'(snap_cyc_q);
        3'd1:    rsp_data = snap_tot_q;
        3'd2:    rsp_data = DW'(snap_lane_q[0]);
        3'd3:    rsp_data = DW'(snap_lane_q[1]);
        3'd4:    rsp_data = DW'(snap_lane_q[2]);
        3'd5:    rsp_data = DW'(snap_lane_q[3]);
        default: rsp_data = '0;
      endcase
    end
  end

  assign bus.rd_ready  = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_idx   = rsp_valid ? idx_q : 3'd0;
  assign bus.rsp_last  = rsp_valid && (idx_q == 3'd5);

endmodule

// File: tb/tb_perf_cnt_rsp.sv
// Drives a 32-bit and a 4-bit counter instance with identical stimulus and checks
// both against a queue-based model of the snapshot stream.
module tb_perf_cnt_rsp;

  logic       clock;
  logic       reset;
  logic [3:0] ex;
  logic       clr;
  logic       rd_req;
  logic       rsp_ready;

  perf_cnt_rsp_if #(.DW(34)) bus_w ();
  perf_cnt_rsp_if #(.DW(6))  bus_n ();

  assign bus_w.rd_req    = rd_req;
  assign bus_w.rsp_ready = rsp_ready;
  assign bus_n.rd_req    = rd_req;
  assign bus_n.rsp_ready = rsp_ready;

  perf_cnt_rsp #(.CNT_W(32)) dut_w (
    .clock (clock),
    .reset (reset),
    .ex    (ex),
    .clr   (clr),
    .bus   (bus_w)
  );

  perf_cnt_rsp #(.CNT_W(4)) dut_n (
    .clock (clock),
    .reset (reset),
    .ex    (ex),
    .clr   (clr),
    .bus   (bus_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [33:0] w;
    logic [5:0]  n;
  } word_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  word_t       m_q[$];
  logic [63:0] m_cyc;
  logic [63:0] m_lane [4];
  logic [3:0]  m_prev;
  bit          m_busy;
  logic [33:0] stream_w [6];
  logic [5:0]  stream_n [6];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each accepted read enqueues the six words it must produce, for both widths.
  function automatic void push_snapshot();
    word_t       wd;
    logic [33:0] tot_w;
    logic [5:0]  tot_n;
    tot_w = 34'(m_lane[0][31:0]) + 34'(m_lane[1][31:0]) + 34'(m_lane[2][31:0]) + 34'(m_lane[3][31:0]);
    tot_n = 6'(m_lane[0][3:0]) + 6'(m_lane[1][3:0]) + 6'(m_lane[2][3:0]) + 6'(m_lane[3][3:0]);
    wd.w = 34'(m_cyc[31:0]);
    wd.n = 6'(m_cyc[3:0]);
    m_q.push_back(wd);
    wd.w = tot_w;
    wd.n = tot_n;
    m_q.push_back(wd);
    for (int i = 0; i < 4; i++) begin
      wd.w = 34'(m_lane[i][31:0]);
      wd.n = 6'(m_lane[i][3:0]);
      m_q.push_back(wd);
    end
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_cyc  = 0;
      m_prev = 0;
      for (int i = 0; i < 4; i++) m_lane[i] = 0;
      m_q.delete();
    end else begin
      m_busy = (m_q.size() != 0);
      if (m_busy && rsp_ready) void'(m_q.pop_front());
      else if (!m_busy && rd_req) push_snapshot();
      if (clr) begin
        m_cyc = 0;
        for (int i = 0; i < 4; i++) m_lane[i] = 0;
      end else begin
        m_cyc++;
        for (int i = 0; i < 4; i++) if (ex[i] && !m_prev[i]) m_lane[i]++;
      end
      m_prev = ex;
    end
  end

  // Outputs are compared on every falling edge once reset has been sampled.
  initial begin
    bit          busy;
    logic [2:0]  e_idx;
    @(posedge clock);
    forever begin
      @(negedge clock);
      busy  = (m_q.size() != 0);
      e_idx = busy ? 3'(6 - m_q.size()) : 3'd0;
      check_output("w_rd_ready",  64'(bus_w.rd_ready),  64'(!busy && !reset));
      check_output("w_rsp_valid", 64'(bus_w.rsp_valid), 64'(busy));
      check_output("w_rsp_idx",   64'(bus_w.rsp_idx),   64'(e_idx));
      check_output("w_rsp_last",  64'(bus_w.rsp_last),  64'(busy && m_q.size() == 1));
      check_output("w_rsp_data",  64'(bus_w.rsp_data),  busy ? 64'(m_q[0].w) : 64'd0);
      check_output("n_rd_ready",  64'(bus_n.rd_ready),  64'(!busy && !reset));
      check_output("n_rsp_valid", 64'(bus_n.rsp_valid), 64'(busy));
      check_output("n_rsp_idx",   64'(bus_n.rsp_idx),   64'(e_idx));
      check_output("n_rsp_last",  64'(bus_n.rsp_last),  64'(busy && m_q.size() == 1));
      check_output("n_rsp_data",  64'(bus_n.rsp_data),  busy ? 64'(m_q[0].n) : 64'd0);
      if (bus_w.rsp_valid && rsp_ready) stream_w[bus_w.rsp_idx] = bus_w.rsp_data;
      if (bus_n.rsp_valid && rsp_ready) stream_n[bus_n.rsp_idx] = bus_n.rsp_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: ready high, 1: random ready, 2: stall at idx2 while poking ex/clr, 3: reset at idx3
  task automatic read_stream(input int mode);
    int guard;
    int stall;
    bit did_rst;
    for (int i = 0; i < 6; i++) begin
      stream_w[i] = '1;
      stream_n[i] = '1;
    end
    rsp_ready = 1'b1;
    rd_req    = 1'b1;
    guard     = 0;
    while (m_q.size() == 0 && guard < 20) begin
      tick();
      guard++;
    end
    rd_req = 1'b0;
    if (m_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept within 20 cycles");
      return;
    end
    guard   = 0;
    stall   = 0;
    did_rst = 1'b0;
    while (m_q.size() != 0 && guard < 200) begin
      case (mode)
        1: rsp_ready = 1'($urandom_range(0, 1));
        2: begin
          if (m_q.size() == 4 && stall < 4) begin
            rsp_ready = 1'b0;
            ex        = (stall == 0 || stall == 2) ? 4'hF : 4'h0;
            clr       = (stall == 1);
            stall++;
          end else begin
            rsp_ready = 1'b1;
            ex        = 4'h0;
            clr       = 1'b0;
          end
        end
        3: begin
          rsp_ready = 1'b1;
          if (m_q.size() == 3 && !did_rst) begin
            reset   = 1'b1;
            did_rst = 1'b1;
          end
        end
        default: rsp_ready = 1'b1;
      endcase
      tick();
      guard++;
    end
    reset     = 1'b0;
    rsp_ready = 1'b1;
    ex        = 4'h0;
    clr       = 1'b0;
    if (guard >= 200) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL stream_timeout: got %0d words left, expected 0", m_q.size());
    end
  endtask

  task automatic apply_stimulus();
    // Idle count after reset.
    reset = 1'b0;
    repeat (10) tick();
    read_stream(0);
    check_output("t1_cyc", 64'(stream_w[0]), 64'd10);
    check_output("t1_tot", 64'(stream_w[1]), 64'd0);
    check_output("t1_l4",  64'(stream_w[5]), 64'd0);

    // Held-high lane counts once; toggled lane counts each rise.
    for (int k = 0; k < 6; k++) begin
      ex = {1'b0, (k % 2 == 0), 1'b0, (k < 5)};
      tick();
    end
    ex = 4'h0;
    read_stream(1);
    check_output("t2_tot", 64'(stream_w[1]), 64'd4);
    check_output("t2_l1",  64'(stream_w[2]), 64'd1);
    check_output("t2_l2",  64'(stream_w[3]), 64'd0);
    check_output("t2_l3",  64'(stream_w[4]), 64'd3);
    check_output("t2_l4",  64'(stream_w[5]), 64'd0);

    // Simultaneous rises on all lanes.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 14; k++) begin
      ex = (k % 2 == 0) ? 4'hF : 4'h0;
      tick();
    end
    ex = 4'h0;
    read_stream(0);
    check_output("t3_tot", 64'(stream_w[1]), 64'd28);
    check_output("t3_l1",  64'(stream_w[2]), 64'd7);
    check_output("t3_l4",  64'(stream_w[5]), 64'd7);

    // Backpressure with events and clear underneath the frozen snapshot.
    read_stream(2);
    check_output("t4_tot",  64'(stream_w[1]), 64'd28);
    check_output("t4_l3",   64'(stream_w[4]), 64'd7);
    read_stream(0);
    check_output("t4b_tot", 64'(stream_w[1]), 64'd4);
    check_output("t4b_l2",  64'(stream_w[3]), 64'd1);

    // Narrow-instance wrap of cycle and lane counters.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 33; k++) begin
      ex = (k % 2 == 0 && k < 32) ? 4'b0001 : 4'b0000;
      tick();
    end
    ex = 4'h0;
    read_stream(0);
    check_output("t5_w_cyc", 64'(stream_w[0]), 64'd33);
    check_output("t5_w_l1",  64'(stream_w[2]), 64'd16);
    check_output("t5_n_cyc", 64'(stream_n[0]), 64'd1);
    check_output("t5_n_l1",  64'(stream_n[2]), 64'd0);

    // Narrow total must use the wider response width.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 30; k++) begin
      ex = (k % 2 == 0) ? 4'hF : 4'h0;
      tick();
    end
    ex = 4'h0;
    read_stream(1);
    check_output("t5b_n_tot", 64'(stream_n[1]), 64'd60);
    check_output("t5b_n_l4",  64'(stream_n[5]), 64'd15);
    check_output("t5b_w_tot", 64'(stream_w[1]), 64'd60);

    // Reset mid-stream aborts; counters restart from zero.
    read_stream(3);
    check_output("t6_valid", 64'(bus_w.rsp_valid), 64'd0);
    repeat (3) tick();
    read_stream(0);
    check_output("t6_cyc",   64'(stream_w[0]), 64'd3);
    check_output("t6_n_cyc", 64'(stream_n[0]), 64'd3);
    check_output("t6_tot",   64'(stream_w[1]), 64'd0);

    // Random traffic, including requests during SEND and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      ex        = 4'($urandom);
      clr       = ($urandom_range(0, 31) == 0);
      rd_req    = ($urandom_range(0, 3) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    ex        = 4'h0;
    clr       = 1'b0;
    rd_req    = 1'b0;
    rsp_ready = 1'b1;
    reset     = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    reset     = 1'b1;
    ex        = 4'h0;
    clr       = 1'b0;
    rd_req    = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    check_output("rst_rd_ready", 64'(bus_w.rd_ready),  64'd0);
    check_output("rst_valid",    64'(bus_w.rsp_valid), 64'd0);
    check_output("rst_data",     64'(bus_w.rsp_data),  64'd0);
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
